// File: rtl/bet_pkg.sv
// rtl/bet_pkg.sv - shared BET codes, legality helper and writer state enum
//
// Purpose: common definitions for the binary-encoded-ternary latch writer.
// Ports: none (package).

package bet_pkg;

    localparam logic [1:0] BET_NEG     = 2'b01;
    localparam logic [1:0] BET_ZERO    = 2'b11;
    localparam logic [1:0] BET_POS     = 2'b10;
    localparam logic [1:0] BET_ILLEGAL = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } bet_wr_state_e;

    function automatic logic bet_is_legal(input logic [1:0] trit);
        return trit != BET_ILLEGAL;
    endfunction

endpackage

// File: rtl/bet_trit_sanitize.sv
// rtl/bet_trit_sanitize.sv - per-trit 00->11 substitution with legality flag
//
// Purpose: combinational cleanup of one BET trit so the illegal code never reaches the bus.
// Ports:
//   in_trit   in   2  raw BET trit
//   out_trit  out  2  in_trit, or BET_ZERO when in_trit is illegal
//   legal     out  1  1 when in_trit is a legal BET code

module bet_trit_sanitize
    import bet_pkg::*;
(
    input  logic [1:0] in_trit,
    output logic [1:0] out_trit,
    output logic       legal
);

    assign legal    = bet_is_legal(in_trit);
    assign out_trit = legal ? in_trit : BET_ZERO;

endmodule

// File: rtl/bet_trit_latch_writer.sv
// rtl/bet_trit_latch_writer.sv - serialises a BET word onto a 2-wire bus with a latch strobe
//
// Purpose: accept an NTRITS word on a valid/ready handshake and drive it one trit per frame
// (SETUP / STROBE / HOLD) onto out_trit with a level enable for TD-latch cells.
// Ports:
//   clk, rst      in   1         clock, synchronous active-high reset
//   in_valid      in   1         in_word is valid
//   in_ready      out  1         writer is idle and can accept a word
//   in_word       in   2*NTRITS  BET word, trit i = in_word[2i+1:2i]
//   out_trit      out  2         BET data to the latch (never 2'b00)
//   out_en        out  1         latch enable, transparent while high
//   out_idx       out  IDX_W     index of the trit on out_trit
//   busy          out  1         a word is being serialised
//   done          out  1         one-cycle pulse after the final HOLD
//   err_illegal   out  1         one-cycle pulse after accepting a word with an illegal trit

module bet_trit_latch_writer
    import bet_pkg::*;
#(
    parameter int NTRITS    = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 1,
    localparam int IDX_W    = (NTRITS > 1) ? $clog2(NTRITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*NTRITS-1:0] in_word,
    output logic [1:0]          out_trit,
    output logic                out_en,
    output logic [IDX_W-1:0]    out_idx,
    output logic                busy,
    output logic                done,
    output logic                err_illegal
);

    localparam int PH_MAX = (SETUP_CYC > EN_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]  EN_LAST    = PH_W'(EN_CYC - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NTRITS - 1);

    logic [2*NTRITS-1:0] san_word;
    logic [NTRITS-1:0]   trit_legal;

    for (genvar g = 0; g < NTRITS; g++) begin : g_san
        bet_trit_sanitize u_san (
            .in_trit  (in_word[2*g +: 2]),
            .out_trit (san_word[2*g +: 2]),
            .legal    (trit_legal[g])
        );
    end

    bet_wr_state_e       state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2*NTRITS-1:0] shift_q, shift_d;
    logic [1:0]          trit_q, trit_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        trit_d  = trit_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                trit_d = BET_ZERO;
                en_d   = 1'b0;
                busy_d = 1'b0;
                idx_d  = '0;
                ph_d   = '0;
                if (in_valid) begin
                    // Trit 0 goes straight onto the bus; the remainder waits in the shifter.
                    state_d = SETUP;
                    trit_d  = san_word[1:0];
                    shift_d = san_word >> 2;
                    err_d   = ~&trit_legal;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = STROBE;
                    ph_d    = '0;
                    en_d    = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            STROBE: begin
                if (ph_q == EN_LAST) begin
                    state_d = HOLD;
                    ph_d    = '0;
                    en_d    = 1'b0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    ph_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                        trit_d  = BET_ZERO;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Data only ever moves on SETUP entry, when out_en is already low.
                        state_d = SETUP;
                        trit_d  = shift_q[1:0];
                        shift_d = shift_q >> 2;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            trit_q  <= BET_ZERO;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            trit_q  <= trit_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_trit    = trit_q;
    assign out_en      = en_q;
    assign out_idx     = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_illegal = err_q;

endmodule
